// File: rtl/tap_tempo.sv
// Tap-tempo front end: times the gap between button taps and turns it
// into a bpm value with a load strobe for the beat generator.
module tap_tempo #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned MIN_BPM = 30,
    parameter int unsigned MAX_BPM = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tap,
    output logic [7:0] bpm,
    output logic       load_bpm,
    output logic       busy,
    output logic       locked
);

    localparam logic [31:0] CYC_MIN = 32'(60 * CLK_HZ);
    localparam logic [31:0] MINP    = CYC_MIN / 32'(MAX_BPM);
    localparam logic [31:0] TO      = CYC_MIN / 32'(MIN_BPM);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE
    } state_t;

    state_t state, state_n;

    logic        s1, s2, s3;
    logic        tap_edge;
    logic [31:0] cnt;
    logic [31:0] prev_iv;
    logic        hist;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [4:0]  iter;

    logic        timeout;
    logic        accept;
    logic        restart;
    logic [31:0] avg;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        qbit;
    logic        last;

    assign tap_edge = s2 & ~s3;
    assign timeout  = (state == MEASURE) && (cnt > TO);
    assign accept   = (state == MEASURE) && tap_edge && !timeout
                      && (cnt >= MINP);
    assign restart  = ((state == IDLE) && tap_edge) || accept;

    // Overflow-free truncated mean of two 32-bit intervals
    assign avg    = cnt[31:1] + prev_iv[31:1]
                    + {31'd0, cnt[0] & prev_iv[0]};

    assign rem_sh = {rem, quo[31]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign qbit   = ~diff[32];
    assign last   = (iter == 5'd31);

    assign busy   = (state == DIVIDE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (tap_edge) state_n = MEASURE;
            MEASURE: begin
                if (timeout) begin
                    state_n = IDLE;
                end else if (accept) begin
                    state_n = DIVIDE;
                end
            end
            DIVIDE:  if (last) state_n = MEASURE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            cnt      <= '0;
            prev_iv  <= '0;
            hist     <= 1'b0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            iter     <= '0;
            bpm      <= 8'd120;
            load_bpm <= 1'b0;
            locked   <= 1'b0;
        end else begin
            s1       <= tap;
            s2       <= s1;
            s3       <= s2;
            load_bpm <= 1'b0;

            // Cleared on the edge cycle itself, so the next edge reads B-A
            if (restart) begin
                cnt <= 32'd1;
            end else if (cnt != '1) begin
                cnt <= cnt + 32'd1;
            end

            if (timeout) begin
                hist <= 1'b0;
            end

            if (accept) begin
                prev_iv <= cnt;
                hist    <= 1'b1;
                dvs     <= hist ? avg : cnt;
                rem     <= '0;
                quo     <= CYC_MIN;
                iter    <= '0;
            end

            if (state == DIVIDE) begin
                rem  <= qbit ? diff[31:0] : rem_sh[31:0];
                quo  <= {quo[30:0], qbit};
                iter <= iter + 5'd1;
                if (last) begin
                    bpm      <= {quo[6:0], qbit};
                    load_bpm <= 1'b1;
                    locked   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tap_tempo.sv
// Directed bench for tap_tempo at CLK_HZ=1000:
// MINP=235, TO=2000, CYC_MIN=60000.
module tb_tap_tempo;

    logic       clk;
    logic       reset;
    logic       tap;
    logic [7:0] bpm;
    logic       load_bpm;
    logic       busy;
    logic       locked;

    int vectors;
    int miscompares;
    int cyc;
    int nloads;
    int last_bpm;
    int load_cyc;
    int tap_cyc;
    int bcnt;
    int n0;

    tap_tempo #(
        .CLK_HZ (1000),
        .MIN_BPM(30),
        .MAX_BPM(255)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tap     (tap),
        .bpm     (bpm),
        .load_bpm(load_bpm),
        .busy    (busy),
        .locked  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        nloads   = 0;
        last_bpm = -1;
        load_cyc = 0;
        bcnt     = 0;
    end

    always @(negedge clk) begin
        if (load_bpm) begin
            nloads++;
            last_bpm = int'(bpm);
            load_cyc = cyc;
        end
        if (busy) bcnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tap();
        tap     = 1'b1;
        tap_cyc = cyc;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 tap = 1'b0;
            end
        join_none
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        tap         = 1'b0;
        step(3);
        chk("rst_bpm", int'(bpm), 120);
        chk("rst_load", int'(load_bpm), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_locked", int'(locked), 0);
        reset = 1'b1;
        step(5);

        // Basic interval 500 -> 120, latency and busy length
        do_tap();
        step(500);
        bcnt = 0;
        do_tap();
        step(40);
        chk("t1_loads", nloads, 1);
        chk("t1_bpm", int'(bpm), 120);
        chk("t1_locked", int'(locked), 1);
        chk("t1_latency", load_cyc - tap_cyc, 35);
        chk("t1_busy_len", bcnt, 32);

        // Interval 600 averaged with 500 -> 60000/550
        step(560);
        do_tap();
        step(40);
        chk("avg_loads", nloads, 2);
        chk("avg_bpm", last_bpm, 109);

        // Timeout holds output and clears history
        step(2100);
        chk("to_bpm_hold", int'(bpm), 109);
        chk("to_locked", int'(locked), 1);
        chk("to_loads", nloads, 2);
        do_tap();
        step(1000);
        do_tap();
        step(40);
        chk("to_new_bpm", int'(bpm), 60);
        chk("to_new_loads", nloads, 3);

        // Bounce at +100 ignored, interval measured as 500
        step(2100);
        do_tap();
        step(100);
        do_tap();
        step(400);
        do_tap();
        step(40);
        chk("bnc_loads", nloads, 4);
        chk("bnc_bpm", int'(bpm), 120);

        // Fastest tempo
        step(2100);
        do_tap();
        step(235);
        do_tap();
        step(40);
        chk("min_iv_bpm", int'(bpm), 255);
        chk("min_iv_loads", nloads, 5);

        // Slowest tempo
        step(2100);
        do_tap();
        step(2000);
        do_tap();
        step(40);
        chk("max_iv_bpm", int'(bpm), 30);
        chk("max_iv_loads", nloads, 6);

        // One past the timeout: edge loses to timeout
        step(2100);
        do_tap();
        step(2001);
        do_tap();
        step(40);
        chk("over_iv_loads", nloads, 6);
        chk("over_iv_bpm", int'(bpm), 30);

        // Reset in the middle of a division
        step(2100);
        do_tap();
        step(500);
        do_tap();
        step(12);
        chk("rd_busy_pre", int'(busy), 1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("rd_bpm", int'(bpm), 120);
        chk("rd_locked", int'(locked), 0);
        chk("rd_busy", int'(busy), 0);
        chk("rd_load", int'(load_bpm), 0);
        n0 = nloads;
        step(40);
        chk("rd_no_load", nloads, n0);
        do_tap();
        step(600);
        do_tap();
        step(40);
        chk("rd_after_bpm", int'(bpm), 100);
        chk("rd_after_loads", nloads, n0 + 1);
        chk("rd_after_lock", int'(locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
